// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray counter source and the Gray-to-binary converter.
package gray_pkg;

  // Widest code the helpers handle; callers zero-extend to this width and truncate back.
  localparam int unsigned MaxWidth = 32;

  // Output slot occupancy.
  typedef enum logic {SlotEmpty, SlotFull} slot_state_e;

  // Binary to reflected Gray code.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // 1 when the count sits at the end of the range for the step direction.
  function automatic logic terminal(input logic [MaxWidth-1:0] cnt, input logic up,
                                    input int unsigned width);
    logic [MaxWidth-1:0] max_val;
    if (width >= MaxWidth) max_val = '1;
    else max_val = (MaxWidth'(1) << width) - MaxWidth'(1);
    return up ? (cnt == max_val) : (cnt == '0);
  endfunction

endpackage

// File: rtl/gray_counter_src.sv
// Gray-code counter source: emits the Gray code of a binary count into a one-entry
// output slot with valid/ready handshake, then steps the count up or down.
module gray_counter_src
  import gray_pkg::*;
#(
  parameter int unsigned SIZE = 8,
  parameter int unsigned WRAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  output logic [SIZE-1:0] gray_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            tc
);

  logic [SIZE-1:0] r_cnt;
  logic [SIZE-1:0] r_gray;
  logic            r_tc;
  slot_state_e     r_state;

  logic            w_space;
  logic            w_emit;
  logic            w_term;
  logic [SIZE-1:0] w_gray_cnt;
  logic [SIZE-1:0] w_cnt_step;
  logic [SIZE-1:0] w_cnt_next;
  logic [SIZE-1:0] w_gray_next;
  logic            w_tc_next;
  slot_state_e     w_state_next;

  assign w_space    = (r_state == SlotEmpty) || out_ready;
  // Load wins over en, so a load cycle never emits.
  assign w_emit     = en && !load && w_space;
  assign w_gray_cnt = SIZE'(bin2gray(MaxWidth'(r_cnt)));
  assign w_term     = terminal(MaxWidth'(r_cnt), up, SIZE);

  // Next count: step with wrap via modular arithmetic, or hold at the end when saturating.
  always_comb begin
    w_cnt_step = r_cnt;
    if (!(w_term && (WRAP == 0))) begin
      w_cnt_step = up ? (r_cnt + SIZE'(1)) : (r_cnt - SIZE'(1));
    end
  end

  // Next-state for counter, output slot and registered outputs.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_gray_next  = r_gray;
    w_tc_next    = r_tc;
    w_state_next = r_state;
    if (load) begin
      w_cnt_next = load_bin;
    end else if (w_emit) begin
      w_cnt_next = w_cnt_step;
    end
    if (w_emit) begin
      w_gray_next  = w_gray_cnt;
      w_tc_next    = w_term;
      w_state_next = SlotFull;
    end else if ((r_state == SlotFull) && out_ready) begin
      w_state_next = SlotEmpty;
    end
  end

  // State registers with synchronous reset; reset drops any pending code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_gray  <= '0;
      r_tc    <= 1'b0;
      r_state <= SlotEmpty;
    end else begin
      r_cnt   <= w_cnt_next;
      r_gray  <= w_gray_next;
      r_tc    <= w_tc_next;
      r_state <= w_state_next;
    end
  end

  assign gray_out  = r_gray;
  assign tc        = r_tc;
  assign out_valid = (r_state == SlotFull);

endmodule

// File: tb/tb_gray_counter_src.sv
// Directed self-checking bench for gray_counter_src at SIZE=4, wrapping and saturating.
module tb_gray_counter_src;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load, out_ready;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray_w, gray_s;
  logic         valid_w, valid_s, tc_w, tc_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_counter_src #(.SIZE(W), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray_out(gray_w), .out_valid(valid_w), .out_ready(out_ready), .tc(tc_w)
  );

  gray_counter_src #(.SIZE(W), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray_out(gray_s), .out_valid(valid_s), .out_ready(out_ready), .tc(tc_s)
  );

  typedef struct {
    logic         rst, en, up, load;
    logic [W-1:0] lb;
    logic         rdy;
    logic         v;
    logic [W-1:0] g;
    logic         t;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lb, input logic rd);
    rst = r; en = e; up = u; load = l; load_bin = lb; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string name, input logic v, input logic [W-1:0] g,
                         input logic t);
    check({name, ".valid"}, W'(valid_w), W'(v));
    check({name, ".gray"}, gray_w, g);
    check({name, ".tc"}, W'(tc_w), W'(t));
  endtask

  task automatic check_s(input string name, input logic v, input logic [W-1:0] g,
                         input logic t);
    check({name, ".sat_valid"}, W'(valid_s), W'(v));
    check({name, ".sat_gray"}, gray_s, g);
    check({name, ".sat_tc"}, W'(tc_s), W'(t));
  endtask

  logic [W-1:0] prev_g, diff;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0; out_ready = 1'b0;

    //              rst  en   up   load lb     rdy   v    g        t
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0});
    // Count up from reset.
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0001, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0011, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0010, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0110, 1'b0});
    // Backpressure: emit 0000, 0001, then stall 4 cycles with en held.
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0001, 1'b0});
    for (int i = 0; i < 4; i++)
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0001, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0011, 1'b0});
    // Consume without emitting: slot empties, code held.
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'b0011, 1'b0});
    // Load 15 with en high: no emit; then wrap up through terminal count.
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 4'b0011, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b1000, 1'b1});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b0});
    // Load 0 and count down through the low end.
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b1});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'b1000, 1'b0});
    // Load while full and stalled: outputs hold; then emit the loaded count 5.
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 4'b1000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'b0111, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].en, vq[i].up, vq[i].load, vq[i].lb, vq[i].rdy);
      check_w($sformatf("vec%0d", i), vq[i].v, vq[i].g, vq[i].t);
    end

    // Reset while full and stalled drops the code; next emit is 0000.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check_w("stall_hold", 1'b1, 4'b0111, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check_w("rst_full", 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_w("post_rst", 1'b1, 4'b0000, 1'b0);

    // Top end: wrapping vs saturating instance.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1);
    check_s("sat_load", 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_w("top1", 1'b1, 4'b1000, 1'b1);
    check_s("top1", 1'b1, 4'b1000, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_w("top2", 1'b1, 4'b0000, 1'b0);
    check_s("top2", 1'b1, 4'b1000, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_w("top3", 1'b1, 4'b0001, 1'b0);
    check_s("top3", 1'b1, 4'b1000, 1'b1);

    // Bottom end when counting down.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    check_w("bot1", 1'b1, 4'b0000, 1'b1);
    check_s("bot1", 1'b1, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    check_w("bot2", 1'b1, 4'b1000, 1'b0);
    check_s("bot2", 1'b1, 4'b0000, 1'b1);

    // Consecutive up emits across the wrap differ in exactly one bit.
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    prev_g = gray_w;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      diff = gray_w ^ prev_g;
      check($sformatf("onebit%0d", i), W'($countones(diff)), W'(1));
      prev_g = gray_w;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter_src.md
GRAY_COUNTER_SRC -- requirements
Module: gray_counter_src

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the counter and code width in bits.
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap at the ends of the range, 0 = saturate at the ends.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: en  input  1  request to emit the current count and then step.
REQ-007 SHALL have port: up  input  1  step direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port: load  input  1  load the binary count from load_bin.
REQ-009 SHALL have port: load_bin  input  SIZE  binary value to load.
REQ-010 SHALL have port: gray_out  output  SIZE  registered Gray code of the emitted count.
REQ-011 SHALL have port: out_valid  output  1  gray_out holds an unconsumed code.
REQ-012 SHALL have port: out_ready  input  1  downstream (Gray-to-binary converter) accepts gray_out.
REQ-013 SHALL have port: tc  output  1  the emitted code is the terminal count for its direction.

Function
REQ-014 SHALL keep an internal binary count register cnt[SIZE-1:0]; the Gray code SHALL be cnt ^ (cnt >> 1).
REQ-015 SHALL model the output as a one-entry slot with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define "space" as !out_valid || out_ready.
REQ-017 SHALL perform an emit when en=1, load=0 and space=1. An emit does all of the following on the same edge:
  - gray_out <= gray(cnt)
  - tc <= terminal(cnt, up)
  - out_valid <= 1
  - cnt steps by one.
REQ-018 SHALL, when the slot is FULL, out_ready=1 and no emit occurs, set out_valid <= 0; gray_out and tc then hold their values.
REQ-019 SHALL, when the slot is FULL and out_ready=0, hold gray_out, tc, out_valid and cnt unchanged (backpressure); en is ignored.
REQ-020 SHALL, when load=1, set cnt <= load_bin. Load has priority over en, so no emit occurs that cycle; the output slot follows REQ-018/019.
REQ-021 SHALL compute terminal(cnt, up) as 1 when (up=1 and cnt = 2^SIZE-1) or (up=0 and cnt = 0), else 0.
REQ-022 SHALL step as follows when the terminal condition holds:
  - WRAP=1: cnt wraps (max+1 -> 0, 0-1 -> max)
  - WRAP=0: cnt holds, so repeated emits return the same code with tc=1.
REQ-023 SHALL have emit latency of one cycle: the code appears on gray_out the edge after the emit request is sampled.
REQ-024 SHALL sustain one emit per cycle while en=1 and out_ready=1.
REQ-025 SHALL change only one bit of gray_out between consecutive emits in the same direction without load, including across the wrap.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set cnt=0, gray_out=0, out_valid=0 and tc=0, overriding load and en.
REQ-027 SHALL, when reset is asserted mid-operation (slot FULL), drop the pending code without a handshake; out_valid=0 in the next cycle.
REQ-028 SHALL accept the first emit in the cycle after rst deasserts.

Structure
REQ-029 SHALL place the bin-to-Gray function and the terminal-count function in the shared gray package, which also serves the Gray-to-binary converter.
REQ-030 SHALL contain no sub-module other than an optional combinational gray_bin2gray instance; the slot and counter remain in this module.

Verification (SIZE=4)
REQ-031 SHALL cover: reset, then en=1, up=1, out_ready=1 for 5 cycles -> gray_out = 0000, 0001, 0011, 0010, 0110 on consecutive cycles, out_valid=1 throughout, tc=0.
REQ-032 SHALL cover: load_bin=15, WRAP=1, then en=1, up=1 for 2 cycles -> gray_out = 1000 with tc=1, then 0000 with tc=0.
REQ-033 SHALL cover: load_bin=15, WRAP=0, then en=1, up=1 for 3 cycles -> gray_out = 1000 three times, tc=1 each time.
REQ-034 SHALL cover: after emitting 0001, hold out_ready=0 for 4 cycles with en=1 -> gray_out stays 0001 and out_valid stays 1; raise out_ready -> next code is 0011, with no code skipped.
REQ-035 SHALL cover: load_bin=0, up=0, en=1 for 2 cycles, WRAP=1 -> gray_out = 0000 with tc=1, then 1000 (count 15) with tc=0.
REQ-036 SHALL cover: assert rst for 1 cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and gray_out=0000; the next emit produces 0000.
